// File: rtl/saturn_bus_controller.sv
// saturn_bus_controller
//   Consumes the 32-entry bus program written by the control unit. Each bus
//   cycle (four enabled clocks, one-hot i_phases) either sends one program
//   entry onto the nibble bus or performs one read cycle, and drives the
//   busy flag that stalls the control unit while entries are in flight.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_clk_en              qualifies every state update
//   i_phases              one-hot bus phase [0]..[3]
//   i_phase, i_cycle_ctr  debug only, not used by the logic
//   i_program_address     producer write pointer (next free entry)
//   i_program_data        entry at o_program_address, [4]=1 command
//   o_program_address     read pointer
//   i_no_read             suppress idle read cycles
//   o_nibble              last nibble read from the bus
//   o_bus_busy            entries pending or being sent
//   o_error               sticky protocol error
//   o_bus_data            nibble driven on the bus
//   o_bus_cmd_data        1 = command nibble, 0 = data nibble
//   o_bus_strobe          one enabled clock in phase 1 of each active cycle
//   i_bus_data            nibble returned by the bus
//   o_bus_address         shadow bus address
//
// Build option
//   SATURN_BUS_ADDR_TRACK_EN  when defined, o_bus_address is loaded at the
//   close of each address load and advances after every read strobe;
//   otherwise it is tied to zero.

module saturn_bus_controller (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic [1:0]  i_phase,
  input  logic [31:0] i_cycle_ctr,
  input  logic [4:0]  i_program_address,
  input  logic [4:0]  i_program_data,
  output logic [4:0]  o_program_address,
  input  logic        i_no_read,
  output logic [3:0]  o_nibble,
  output logic        o_bus_busy,
  output logic        o_error,
  output logic [3:0]  o_bus_data,
  output logic        o_bus_cmd_data,
  output logic        o_bus_strobe,
  input  logic [3:0]  i_bus_data,
  output logic [19:0] o_bus_address
);

  localparam logic [3:0] BUSCMD_LOAD_PC = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP = 4'h5;
  // Command codes above this value are not defined on the bus.
  localparam logic [3:0] BUSCMD_LAST    = 4'h8;

  typedef enum logic [1:0] {IDLE, SEND, LOAD_ADDR, READ} state_t;

  state_t      state_q, state_d;
  logic        pending;
  logic        phase0_en;
  logic        entry_is_cmd;
  logic [3:0]  entry_code;
  logic        cmd_opens_load;
  logic        cmd_known;
  logic        load_open;
  logic [2:0]  load_cnt;
  logic        unused_debug;

  assign unused_debug   = ^{i_phase, i_cycle_ctr};

  assign pending        = (o_program_address != i_program_address);
  assign phase0_en      = i_clk_en & i_phases[0];
  assign entry_is_cmd   = i_program_data[4];
  assign entry_code     = i_program_data[3:0];
  assign cmd_opens_load = (entry_code == BUSCMD_LOAD_PC) || (entry_code == BUSCMD_LOAD_DP);
  assign cmd_known      = (entry_code <= BUSCMD_LAST);

  // Strobe is decoded from the current phase so it is high for exactly the
  // phase-1 enabled clock and never while the clock enable is low.
  assign o_bus_strobe   = i_clk_en & i_phases[1] & (state_q != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (phase0_en) begin
      if (pending)         state_d = load_open ? LOAD_ADDR : SEND;
      else if (!i_no_read) state_d = READ;
      else                 state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_program_address <= '0;
      o_nibble          <= '0;
      o_bus_busy        <= 1'b0;
      o_error           <= 1'b0;
      o_bus_data        <= '0;
      o_bus_cmd_data    <= 1'b0;
      load_open         <= 1'b0;
      load_cnt          <= '0;
    end else if (i_clk_en) begin
      if (i_phases[0]) begin
        if (pending) begin
          o_program_address <= o_program_address + 5'd1;
          o_bus_data        <= entry_code;
          o_bus_cmd_data    <= entry_is_cmd;
          o_bus_busy        <= 1'b1;
          if (entry_is_cmd) begin
            if (load_open) begin
              o_error   <= 1'b1;
              load_open <= 1'b0;
            end else if (cmd_opens_load) begin
              load_open <= 1'b1;
              load_cnt  <= '0;
            end else if (!cmd_known) begin
              o_error <= 1'b1;
            end
          end else if (load_open) begin
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd4) load_open <= 1'b0;
          end else begin
            o_error <= 1'b1;
          end
        end else begin
          o_bus_data     <= '0;
          o_bus_cmd_data <= 1'b0;
        end
      end
      if (i_phases[2] && (state_q == READ)) o_nibble <= i_bus_data;
      if (i_phases[3] && !pending && !load_open) o_bus_busy <= 1'b0;
    end
  end

`ifdef SATURN_BUS_ADDR_TRACK_EN
  // Four earlier nibbles of the address being assembled; the fifth arrives
  // with the closing entry and is placed on top directly.
  logic [15:0] addr_sr;
  logic [19:0] bus_addr_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_sr    <= '0;
      bus_addr_q <= '0;
    end else if (i_clk_en) begin
      if (i_phases[0] && pending && !entry_is_cmd && load_open) begin
        addr_sr <= {entry_code, addr_sr[15:4]};
        if (load_cnt == 3'd4) bus_addr_q <= {entry_code, addr_sr};
      end
      if (i_phases[1] && (state_q == READ)) bus_addr_q <= bus_addr_q + 20'd1;
    end
  end

  assign o_bus_address = bus_addr_q;
`else
  assign o_bus_address = '0;
`endif

endmodule

// File: doc/saturn_bus_controller.md
# saturn_bus_controller

Consumer of the 32-entry bus program filled by the control unit. Walks the program with its own read pointer, serialises command and data entries onto the nibble-wide Saturn bus, and otherwise performs one memory read per bus cycle, returning the nibble to the control unit and decoder. Drives the busy flag that stalls control-unit execution while program entries are in flight.

## Interface
- No parameters.
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_clk_en  in  1  qualifies every state update
- i_phases  in  4  one-hot bus phase, [0]..[3]; one bus cycle = 4 enabled clocks
- i_phase  in  2  phase index, debug only
- i_cycle_ctr  in  32  cycle counter, debug only
- i_program_address  in  5  producer write pointer (next free entry)
- i_program_data  in  5  program entry at o_program_address; [4]=1 command, [4]=0 data nibble
- o_program_address  out  5  read pointer
- i_no_read  in  1  suppress idle read cycles
- o_nibble  out  4  last nibble read from bus
- o_bus_busy  out  1  program entries pending or being sent
- o_error  out  1  sticky protocol error
- o_bus_data  out  4  nibble driven on bus
- o_bus_cmd_data  out  1  1 = command nibble, 0 = data
- o_bus_strobe  out  1  bus strobe, one enabled clock per bus cycle
- i_bus_data  in  4  nibble returned by bus
- o_bus_address  out  20  shadow bus address (see Configuration)

## Operation
- Empty when o_program_address == i_program_address; pending otherwise. Pointer is 5-bit, wraps 31 -> 0. Overrun prevention is the producer's duty; not detected.
- FSM states: IDLE, SEND, LOAD_ADDR, READ.
- Phase 0 decision: pending -> SEND (or LOAD_ADDR if an address load is open); empty and !i_no_read -> READ; else IDLE (no strobe this cycle).
- SEND/LOAD_ADDR: phase 0 latches i_program_data, increments pointer. Phase 1: o_bus_data = entry[3:0], o_bus_cmd_data = entry[4], o_bus_strobe = 1.
- Command `BUSCMD_LOAD_PC` or `BUSCMD_LOAD_DP` opens an address load; the next 5 data entries, LSN first, form the address; 5-nibble counter then closes it and returns to SEND/READ selection.
- Data entry outside an open address load: transmitted, o_error set. Command entry during an open load or unknown command code: transmitted, o_error set, load aborted.
- READ: phase 1 strobe with o_bus_cmd_data = 0, o_bus_data = 0; phase 2 registers i_bus_data into o_nibble.
- o_bus_busy: set at phase 0 when pending; cleared at phase 3 when empty and no address load open.

## Timing
- Reset values: o_program_address 0, o_nibble 0, o_bus_busy 0, o_error 0, o_bus_data 0, o_bus_cmd_data 0, o_bus_strobe 0, o_bus_address 0; FSM IDLE.
- i_clk_en low: all state frozen; o_bus_strobe held 0.
- One entry or one read per bus cycle; strobe only in phase 1, exactly one enabled clock.
- Read latency: o_nibble valid from phase 3 of the same bus cycle, stable until next read's phase 2.
- Write pointer advancing in the same clock as a phase 0 check: new entry seen at next phase 0.
- LOAD_PC + 5 nibbles = 6 bus cycles busy; first READ in 7th cycle.
- Reset mid-transfer: FSM, pointer, counter cleared same clock; no strobe in following clock.

## Configuration
- SATURN_BUS_ADDR_TRACK_EN defined: o_bus_address loads the 20-bit assembled address at close of each address load and increments (mod 2^20) after every READ strobe.
- Undefined: o_bus_address tied to 0; no address register synthesised.

## Test plan
- Reset, write ptr 0, i_no_read 1 -> no strobe for 8 bus cycles, busy 0, all outputs 0.
- Program LOAD_PC, 0,0,0,0,0 at entries 0-5, write ptr 6 -> six strobes, cmd_data 1 then five 0, busy cleared at phase 3 of cycle 6, ptr = 6.
- Then i_no_read 0, bus returns 3,A -> o_nibble 3 then A at phase 3 of successive cycles; with macro, o_bus_address 00000 -> 00001 -> 00002.
- Data entry 7 with no open load -> nibble 7 strobed, o_error 1 and stays 1 until reset.
- Write ptr 30 -> 2 (entries 30,31,0,1) -> four sends, pointer wraps 31 -> 0, ends at 2.
- Assert i_reset during 3rd address nibble -> pointer 0, busy 0, no strobe next clock; fresh LOAD_PC then completes normally.
